// File: rtl/gpu_int_pkg.sv
// Shared constants for the GPU interrupt controller: G_FLAGS field positions, source indices, FSM states.
package gpu_int_pkg;
    localparam int NUM_IRQ   = 5;
    localparam int FLAG_W    = 32;
    localparam int IMASK_BIT = 3;
    localparam int ENA_LSB   = 4;
    localparam int CLR_LSB   = 9;

    localparam int IRQ_CPU  = 0;
    localparam int IRQ_DSP  = 1;
    localparam int IRQ_PIT  = 2;
    localparam int IRQ_OP   = 3;
    localparam int IRQ_BLIT = 4;

    typedef enum logic {IDLE = 1'b0, REQ = 1'b1} int_state_t;
endpackage

// File: rtl/gpu_irq_prio_enc.sv
// Combinational highest-index-wins priority encoder with a valid flag.
module gpu_irq_prio_enc #(
    parameter int N = 5
) (
    input  logic [N-1:0] req,
    output logic [2:0]   vec,
    output logic         valid
);
    always_comb begin
        vec   = 3'd0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                vec   = 3'(i);
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/gpu_int_ctrl.sv
// GPU interrupt controller: edge latch, enables/IMASK, prioritised request to the sequencer.
// Optional sticky overrun flags are built when GPU_INT_OVERRUN_EN is defined.
module gpu_int_ctrl
    import gpu_int_pkg::*;
#(
    parameter int NUM_IRQ = gpu_int_pkg::NUM_IRQ,
    parameter int FLAG_W  = gpu_int_pkg::FLAG_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               go,
    input  logic               flagwr,
    input  logic [FLAG_W-1:0]  gpu_din,
    input  logic               int_ack,
    output logic               int_req,
    output logic [2:0]         int_vec,
    output logic               imask,
    output logic [NUM_IRQ-1:0] int_ena,
    output logic [NUM_IRQ-1:0] int_lat,
    output logic [NUM_IRQ-1:0] overrun
);
    int_state_t         state;
    logic [NUM_IRQ-1:0] irq_q, edge_det, lat_set, clr_sw, clr_ack, pending;
    logic [2:0]         enc_vec;
    logic               enc_valid, ack_fire;
    logic               unused_din;

    assign unused_din = ^{gpu_din[FLAG_W-1:CLR_LSB+NUM_IRQ], gpu_din[IMASK_BIT-1:0]};

    assign edge_det = irq_in & ~irq_q;
    // Registered enable gates latching, so an enable written alongside an edge uses the old value.
    assign lat_set  = edge_det & int_ena;
    assign clr_sw   = flagwr ? gpu_din[CLR_LSB +: NUM_IRQ] : '0;
    assign ack_fire = (state == REQ) && int_ack;
    assign clr_ack  = ack_fire ? (NUM_IRQ'(1) << int_vec) : '0;
    assign pending  = int_lat & int_ena;

    gpu_irq_prio_enc #(.N(NUM_IRQ)) u_enc (
        .req   (pending),
        .vec   (enc_vec),
        .valid (enc_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q   <= '0;
            int_ena <= '0;
            int_lat <= '0;
            imask   <= 1'b0;
        end else begin
            irq_q   <= irq_in;
            int_lat <= (int_lat & ~(clr_sw | clr_ack)) | lat_set;
            if (flagwr)
                int_ena <= gpu_din[ENA_LSB +: NUM_IRQ];
            // Software may only clear IMASK; an ack in the same cycle keeps it set.
            if (ack_fire)
                imask <= 1'b1;
            else if (flagwr && !gpu_din[IMASK_BIT])
                imask <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            int_req <= 1'b0;
            int_vec <= 3'd0;
        end else begin
            case (state)
                IDLE: if (go && !imask && enc_valid) begin
                    state   <= REQ;
                    int_req <= 1'b1;
                    int_vec <= enc_vec;
                end
                REQ: if (int_ack || !go || !pending[int_vec]) begin
                    state   <= IDLE;
                    int_req <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    int_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef GPU_INT_OVERRUN_EN
    logic [NUM_IRQ-1:0] ovr_q;
    always_ff @(posedge clk) begin
        if (reset)
            ovr_q <= '0;
        else
            ovr_q <= (ovr_q & ~clr_sw) | (lat_set & int_lat & ~(clr_sw | clr_ack));
    end
    assign overrun = ovr_q;
`else
    assign overrun = '0;
`endif
endmodule

// File: tb/tb_gpu_int_ctrl.sv
// Directed self-checking bench for gpu_int_ctrl; expected overrun depends on GPU_INT_OVERRUN_EN.
module tb_gpu_int_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  irq_in;
    logic        go, flagwr, int_ack;
    logic [31:0] gpu_din;
    logic        int_req, imask;
    logic [2:0]  int_vec;
    logic [4:0]  int_ena, int_lat, overrun;
    int          n_cmp = 0;
    int          n_err = 0;

    gpu_int_ctrl dut (
        .clk(clk), .reset(reset), .irq_in(irq_in), .go(go), .flagwr(flagwr),
        .gpu_din(gpu_din), .int_ack(int_ack), .int_req(int_req), .int_vec(int_vec),
        .imask(imask), .int_ena(int_ena), .int_lat(int_lat), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; irq_in = '0; go = 1'b0; flagwr = 1'b0; int_ack = 1'b0; gpu_din = '0;
        tick(); tick();
        reset = 1'b0;
        n_cmp++; if ({int_req, int_vec, imask, int_ena, int_lat, overrun} !== 24'h0) begin
            n_err++; $display("FAIL reset_state got %h exp 0", {int_req, int_vec, imask, int_ena, int_lat, overrun}); end
    endtask

    task automatic test_basic();
        flagwr = 1'b1; gpu_din = 32'h10; tick();
        flagwr = 1'b0; irq_in = 5'h01; go = 1'b1; tick();
        n_cmp++; if (int_lat !== 5'h01 || int_req !== 1'b0) begin
            n_err++; $display("FAIL t1_latch lat=%h req=%b exp lat=01 req=0", int_lat, int_req); end
        irq_in = 5'h00; tick();
        n_cmp++; if (int_req !== 1'b1 || int_vec !== 3'd0) begin
            n_err++; $display("FAIL t1_req req=%b vec=%0d exp req=1 vec=0", int_req, int_vec); end
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        n_cmp++; if (int_req !== 1'b0 || imask !== 1'b1 || int_lat !== 5'h00) begin
            n_err++; $display("FAIL t1_ack req=%b imask=%b lat=%h exp 0/1/00", int_req, imask, int_lat); end
    endtask

    task automatic test_priority();
        flagwr = 1'b1; gpu_din = 32'h1F0; tick();
        flagwr = 1'b0; irq_in = 5'h12; tick();
        irq_in = 5'h00; tick();
        n_cmp++; if (int_req !== 1'b1 || int_vec !== 3'd4) begin
            n_err++; $display("FAIL t2_prio req=%b vec=%0d exp req=1 vec=4", int_req, int_vec); end
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        n_cmp++; if (imask !== 1'b1 || int_lat !== 5'h02 || int_req !== 1'b0) begin
            n_err++; $display("FAIL t2_ack imask=%b lat=%h req=%b exp 1/02/0", imask, int_lat, int_req); end
        tick(); tick();
        n_cmp++; if (int_req !== 1'b0) begin
            n_err++; $display("FAIL t2_masked req=%b exp 0", int_req); end
        flagwr = 1'b1; gpu_din = 32'h1F0; tick(); flagwr = 1'b0;
        n_cmp++; if (imask !== 1'b0 || int_ena !== 5'h1F) begin
            n_err++; $display("FAIL t2_rti imask=%b ena=%h exp 0/1f", imask, int_ena); end
        tick();
        n_cmp++; if (int_req !== 1'b1 || int_vec !== 3'd1) begin
            n_err++; $display("FAIL t2_next req=%b vec=%0d exp req=1 vec=1", int_req, int_vec); end
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        flagwr = 1'b1; gpu_din = 32'h1F0; tick(); flagwr = 1'b0;
    endtask

    task automatic test_go_gate();
        go = 1'b0; irq_in = 5'h04; tick();
        irq_in = 5'h00; int_ack = 1'b1; tick(); int_ack = 1'b0; tick();
        n_cmp++; if (int_req !== 1'b0 || int_lat !== 5'h04 || imask !== 1'b0) begin
            n_err++; $display("FAIL t3_nogo req=%b lat=%h imask=%b exp 0/04/0", int_req, int_lat, imask); end
        go = 1'b1; tick();
        n_cmp++; if (int_req !== 1'b1 || int_vec !== 3'd2) begin
            n_err++; $display("FAIL t3_go req=%b vec=%0d exp req=1 vec=2", int_req, int_vec); end
    endtask

    task automatic test_sw_clear();
        flagwr = 1'b1; gpu_din = 32'h9F0; tick(); flagwr = 1'b0;
        n_cmp++; if (int_lat !== 5'h00) begin
            n_err++; $display("FAIL t4_clr lat=%h exp 00", int_lat); end
        tick();
        n_cmp++; if (int_req !== 1'b0 || imask !== 1'b0) begin
            n_err++; $display("FAIL t4_drop req=%b imask=%b exp 0/0", int_req, imask); end
        tick();
        n_cmp++; if (int_req !== 1'b0) begin
            n_err++; $display("FAIL t4_idle req=%b exp 0", int_req); end
    endtask

    task automatic test_set_wins();
        go = 1'b0;
        flagwr = 1'b1; gpu_din = 32'h11F0; irq_in = 5'h08; tick();
        n_cmp++; if (int_lat !== 5'h08) begin
            n_err++; $display("FAIL t5_setwins lat=%h exp 08", int_lat); end
        gpu_din = 32'h1170; irq_in = 5'h00; tick(); flagwr = 1'b0;
        irq_in = 5'h08; tick();
        n_cmp++; if (int_lat !== 5'h00 || int_ena !== 5'h17) begin
            n_err++; $display("FAIL t5_disabled lat=%h ena=%h exp 00/17", int_lat, int_ena); end
        irq_in = 5'h00; tick();
        flagwr = 1'b1; gpu_din = 32'h1F0; irq_in = 5'h08; tick(); flagwr = 1'b0;
        n_cmp++; if (int_lat !== 5'h00 || int_ena !== 5'h1F) begin
            n_err++; $display("FAIL t5_old_ena lat=%h ena=%h exp 00/1f", int_lat, int_ena); end
        irq_in = 5'h00; tick();
    endtask

    task automatic test_overrun();
        logic [4:0] exp_ovr;
`ifdef GPU_INT_OVERRUN_EN
        exp_ovr = 5'h01;
`else
        exp_ovr = 5'h00;
`endif
        flagwr = 1'b1; gpu_din = 32'h3E1F0; tick(); flagwr = 1'b0;
        irq_in = 5'h01; tick(); irq_in = 5'h00; tick();
        n_cmp++; if (overrun !== 5'h00 || int_lat !== 5'h01) begin
            n_err++; $display("FAIL t6_first ovr=%h lat=%h exp 00/01", overrun, int_lat); end
        irq_in = 5'h01; tick(); irq_in = 5'h00; tick();
        n_cmp++; if (overrun !== exp_ovr || int_lat !== 5'h01) begin
            n_err++; $display("FAIL t6_overrun ovr=%h lat=%h exp %h/01", overrun, int_lat, exp_ovr); end
        flagwr = 1'b1; gpu_din = 32'h3F0; tick(); flagwr = 1'b0;
        n_cmp++; if (overrun !== 5'h00 || int_lat !== 5'h00) begin
            n_err++; $display("FAIL t6_clear ovr=%h lat=%h exp 00/00", overrun, int_lat); end
    endtask

    initial begin
        test_reset();
        test_basic();
        flagwr = 1'b1; gpu_din = 32'h0; tick(); flagwr = 1'b0;
        test_priority();
        test_go_gate();
        test_sw_clear();
        test_set_wins();
        test_overrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
